// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared constants for the SPI target peripheral: register indices (address
// bits [3:2] within the 16-byte window), STATUS/CTRL bit positions and the
// frame FSM state type.
// -----------------------------------------------------------------------------
package spi_slave_pkg;

    // Register index = mem_addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bits
    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_BUSY     = 3;

    // CTRL bits
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_sync
// Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES
// flops, followed by a history flop used for edge detection.
//
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   d_i      asynchronous pin
//   level_o  synchronised level
//   rise_o   one-cycle pulse, synchronised level went 0 -> 1
//   fall_o   one-cycle pulse, synchronised level went 1 -> 0
// -----------------------------------------------------------------------------
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // sync_q[0] samples the pin; sync_q[SYNC_STAGES-1] is the usable level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Memory-mapped SPI target, mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first.
// All SPI pins are oversampled on clk; the host must keep each SCLK phase at
// least 4 clk periods long.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   mem_addr/wdata      core data bus address / write data
//   mem_we/mem_re       single-cycle write / read strobes
//   mem_rdata           combinational read data, 0 when not selected
//   ena                 CTRL.EN, drives the pin mux
//   spi_sclk/cs_n/mosi  host pins (asynchronous)
//   spi_miso/miso_oe    data to host and its drive enable
//   irq                 IRQ_EN & (rx_valid | overrun)
//
// Registers (16-byte window): 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS, 0xC CTRL.
// -----------------------------------------------------------------------------
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter logic [31:0] SPI_SLAVE_BASE_ADDR = 32'h4000_6000,
    parameter int          SYNC_STAGES         = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        ena,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq
);

    // ---------------- pin synchronisers ----------------
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(clk), .rst_ni(rst_n), .d_i(spi_sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i(clk), .rst_ni(rst_n), .d_i(spi_cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(clk), .rst_ni(rst_n), .d_i(spi_mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    // Only edges matter for sclk/cs_n and only the level for mosi; the
    // remaining synchroniser outputs and the bus bits outside the register
    // fields are intentionally left unused.
    logic unused_sigs;
    assign unused_sigs = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall,
                           mem_addr[1:0], mem_wdata[31:8]};

    // ---------------- bus decode ----------------
    logic       sel;
    logic [1:0] idx;
    logic       wr, rd, rx_read;

    assign sel     = (mem_addr[31:4] == SPI_SLAVE_BASE_ADDR[31:4]);
    assign idx     = mem_addr[3:2];
    assign wr      = sel & mem_we;
    assign rd      = sel & mem_re;
    assign rx_read = rd & (idx == REG_RXDATA);

    // ---------------- state ----------------
    spi_state_e state_q, state_d;
    logic       en_q, en_d;
    logic       irq_en_q, irq_en_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_full_q, tx_full_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       reload_pend_q, reload_pend_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            en_q          <= 1'b0;
            irq_en_q      <= 1'b0;
            tx_buf_q      <= 8'h00;
            tx_full_q     <= 1'b0;
            tx_shift_q    <= 8'h00;
            rx_shift_q    <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
            bit_cnt_q     <= 3'd0;
            reload_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            en_q          <= en_d;
            irq_en_q      <= irq_en_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            overrun_q     <= overrun_d;
            bit_cnt_q     <= bit_cnt_d;
            reload_pend_q <= reload_pend_d;
        end
    end

    // Next-byte value for MISO: pending TX byte, or 0x00 on underflow.
    logic [7:0] tx_load;
    assign tx_load = tx_full_q ? tx_buf_q : 8'h00;

    // ---------------- next state ----------------
    // Ordering matters: clears (RXDATA read, overrun W1C) come before the
    // FSM so a same-cycle set wins; the TXDATA write comes last so a byte
    // written during a load stays pending for the next frame.
    always_comb begin
        state_d       = state_q;
        en_d          = en_q;
        irq_en_d      = irq_en_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        overrun_d     = overrun_q;
        bit_cnt_d     = bit_cnt_q;
        reload_pend_d = reload_pend_q;

        if (rx_read) begin
            rx_valid_d = 1'b0;
        end
        if (wr && idx == REG_STATUS && mem_wdata[ST_OVERRUN]) begin
            overrun_d = 1'b0;
        end
        if (wr && idx == REG_CTRL) begin
            en_d     = mem_wdata[CTRL_EN];
            irq_en_d = mem_wdata[CTRL_IRQ_EN];
        end

        case (state_q)
            IDLE: begin
                if (cs_fall && en_q) begin
                    state_d       = ACTIVE;
                    tx_shift_d    = tx_load;
                    tx_full_d     = 1'b0;
                    bit_cnt_d     = 3'd0;
                    reload_pend_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (cs_rise || !en_q) begin
                    // Deselect or disable: any partial byte is dropped.
                    state_d       = IDLE;
                    bit_cnt_d     = 3'd0;
                    reload_pend_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_lvl};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d     = {rx_shift_q[6:0], mosi_lvl};
                        rx_valid_d    = 1'b1;
                        bit_cnt_d     = 3'd0;
                        reload_pend_d = 1'b1;
                        if (rx_valid_q && !rx_read) begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (sclk_fall) begin
                    if (reload_pend_q) begin
                        tx_shift_d    = tx_load;
                        tx_full_d     = 1'b0;
                        reload_pend_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr && idx == REG_TXDATA) begin
            tx_buf_d  = mem_wdata[7:0];
            tx_full_d = 1'b1;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        mem_rdata = 32'h0;
        if (rd) begin
            case (idx)
                REG_RXDATA: mem_rdata = {24'h0, rx_data_q};
                REG_STATUS: begin
                    mem_rdata[ST_RX_VALID] = rx_valid_q;
                    mem_rdata[ST_TX_EMPTY] = ~tx_full_q;
                    mem_rdata[ST_OVERRUN]  = overrun_q;
                    mem_rdata[ST_BUSY]     = (state_q == ACTIVE);
                end
                REG_CTRL: begin
                    mem_rdata[CTRL_EN]     = en_q;
                    mem_rdata[CTRL_IRQ_EN] = irq_en_q;
                end
                default: mem_rdata = 32'h0;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign ena         = en_q;
    assign spi_miso    = (state_q == ACTIVE) & tx_shift_q[7];
    assign spi_miso_oe = en_q & (state_q == ACTIVE);
    assign irq         = irq_en_q & (rx_valid_q | overrun_q);

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    localparam logic [31:0] BASE   = 32'h4000_6000;
    localparam logic [31:0] A_TX   = BASE + 32'h0;
    localparam logic [31:0] A_RX   = BASE + 32'h4;
    localparam logic [31:0] A_ST   = BASE + 32'h8;
    localparam logic [31:0] A_CTRL = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic        ena, spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe, irq;

    spi_slave #(.SPI_SLAVE_BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .ena(ena),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model (byte/transaction level) ----------------
    bit         m_en, m_irqen, m_pend, m_rxv, m_ovr;
    logic [7:0] m_buf, m_rxd, m_next;

    task automatic m_reset();
        m_en = 0; m_irqen = 0; m_pend = 0; m_rxv = 0; m_ovr = 0;
        m_buf = 8'h00; m_rxd = 8'h00; m_next = 8'h00;
    endtask

    // Byte the target will shift out next: pending TX byte, else 0x00.
    function automatic logic [7:0] m_take();
        m_take = m_pend ? m_buf : 8'h00;
        m_pend = 0;
    endfunction

    function automatic logic [31:0] m_status(input bit busy);
        m_status = {28'h0, busy, m_ovr, ~m_pend, m_rxv};
    endfunction

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_addr = a; mem_wdata = d; mem_we = 1'b1;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        mem_addr = a; mem_re = 1'b1;
        #2 d = mem_rdata;
        @(negedge clk);
        mem_re = 1'b0;
    endtask

    task automatic w_ctrl(input logic [31:0] v);
        bus_write(A_CTRL, v);
        m_en = v[0]; m_irqen = v[1];
    endtask

    task automatic w_tx(input logic [7:0] b);
        bus_write(A_TX, {24'h0, b});
        m_pend = 1; m_buf = b;
    endtask

    task automatic w1c_ovr();
        bus_write(A_ST, 32'h4);
        m_ovr = 0;
    endtask

    task automatic rd_rx(input string name);
        logic [31:0] d;
        bus_read(A_RX, d);
        check(name, d, {24'h0, m_rxd});
        m_rxv = 0;
    endtask

    task automatic rd_st(input string name, input bit busy);
        logic [31:0] d;
        bus_read(A_ST, d);
        check(name, d, m_status(busy));
    endtask

    task automatic chk_irq(input string name);
        check(name, irq, m_irqen & (m_rxv | m_ovr));
    endtask

    // ---------------- SPI host (SCLK = clk/8) ----------------
    task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            mi = {mi[6:0], spi_miso};
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_begin();
        cs_low();
        if (m_en) m_next = m_take();
    endtask

    // Full byte with the target enabled: checks what the host received
    // and updates the model's receive side.
    task automatic frame_byte(input logic [7:0] mo, input string name);
        logic [7:0] mi;
        spi_byte(mo, 8, mi);
        check(name, {24'h0, mi}, {24'h0, m_next});
        if (m_rxv) m_ovr = 1;
        m_rxd  = mo;
        m_rxv  = 1;
        m_next = m_take();
    endtask

    // ---------------- register access table ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  mi;
        int          nb;

        rst_n = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_we = 1'b0; mem_re = 1'b0;
        spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check("reset ena", ena, 0);
        check("reset miso", spi_miso, 0);
        check("reset miso_oe", spi_miso_oe, 0);
        check("reset irq", irq, 0);
        check("reset rdata", mem_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0]  = '{1'b0, A_CTRL,          32'h0,         32'h0};
        vecs[1]  = '{1'b0, A_ST,            32'h0,         32'h2};
        vecs[2]  = '{1'b1, A_CTRL,          32'h3,         32'h0};
        vecs[3]  = '{1'b0, A_CTRL,          32'h0,         32'h3};
        vecs[4]  = '{1'b0, A_TX,            32'h0,         32'h0};
        vecs[5]  = '{1'b1, A_TX,            32'h5A,        32'h0};
        vecs[6]  = '{1'b0, A_ST,            32'h0,         32'h0};
        vecs[7]  = '{1'b0, BASE + 32'h1C,   32'h0,         32'h0};
        vecs[8]  = '{1'b0, 32'h4000_7008,   32'h0,         32'h0};
        vecs[9]  = '{1'b1, A_CTRL,          32'h1,         32'h0};
        vecs[10] = '{1'b0, A_CTRL,          32'h0,         32'h1};
        vecs[11] = '{1'b1, A_CTRL,          32'hFFFF_FFFC, 32'h0};
        vecs[12] = '{1'b1, A_TX,            32'h77,        32'h0};
        vecs[13] = '{1'b0, A_CTRL,          32'h0,         32'h0};
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].data);
                if (vecs[i].addr == A_CTRL) begin m_en = vecs[i].data[0]; m_irqen = vecs[i].data[1]; end
                if (vecs[i].addr == A_TX)   begin m_pend = 1; m_buf = vecs[i].data[7:0]; end
            end else begin
                bus_read(vecs[i].addr, d);
                check($sformatf("regvec%0d", i), d, vecs[i].exp);
            end
        end
        check("ena after table", ena, 0);

        // Single frame
        w_ctrl(32'h3);
        check("ena set", ena, 1);
        w_tx(8'hA5);
        frame_begin();
        check("miso_oe active", spi_miso_oe, 1);
        frame_byte(8'h3C, "single host rx");
        cs_high();
        rd_st("single status", 0);
        chk_irq("single irq set");
        rd_rx("single rxdata");
        chk_irq("single irq clr");
        rd_st("single status after read", 0);

        // Back-to-back with mid-byte TXDATA write
        w_tx(8'h55);
        frame_begin();
        fork
            frame_byte(8'h11, "b2b host rx1");
            begin repeat (20) @(negedge clk); w_tx(8'h66); end
        join
        rd_rx("b2b rxdata1");
        frame_byte(8'h22, "b2b host rx2");
        rd_rx("b2b rxdata2");
        cs_high();
        rd_st("b2b status", 0);

        // Overrun
        frame_begin();
        frame_byte(8'h01, "ovr host rx1");
        frame_byte(8'h02, "ovr host rx2");
        cs_high();
        rd_st("ovr status", 0);
        chk_irq("ovr irq");
        rd_rx("ovr rxdata");
        w1c_ovr();
        rd_st("ovr status cleared", 0);

        // Underflow, then abort after 5 bits, then a clean frame
        frame_begin();
        frame_byte(8'h9C, "underflow host rx");
        cs_high();
        rd_rx("underflow rxdata");
        frame_begin();
        spi_byte(8'hFF, 5, mi);
        check("abort partial miso", {24'h0, mi}, 0);
        rd_st("abort busy", 1);
        cs_high();
        rd_st("abort status", 0);
        frame_begin();
        frame_byte(8'h5E, "post-abort host rx");
        cs_high();
        rd_rx("post-abort rxdata");

        // EN cleared mid-frame, then clocking while disabled
        frame_begin();
        spi_byte(8'hA0, 3, mi);
        w_ctrl(32'h2);
        check("disable miso_oe", spi_miso_oe, 0);
        rd_st("disable busy", 0);
        cs_high();
        frame_begin();
        spi_byte(8'hAA, 8, mi);
        check("disabled miso_oe", spi_miso_oe, 0);
        cs_high();
        rd_st("disabled status", 0);

        // Randomised frames against the model
        w_ctrl(32'h3);
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(1, 0) == 1) w_tx(8'($urandom));
            frame_begin();
            nb = $urandom_range(3, 1);
            for (int b = 0; b < nb; b++) begin
                frame_byte(8'($urandom), $sformatf("rnd f%0d b%0d host rx", f, b));
                if ($urandom_range(1, 0) == 1) rd_rx($sformatf("rnd f%0d b%0d rxdata", f, b));
                if ($urandom_range(3, 0) == 0) w_tx(8'($urandom));
            end
            cs_high();
            rd_st($sformatf("rnd f%0d status", f), 0);
            chk_irq($sformatf("rnd f%0d irq", f));
            if (m_ovr && $urandom_range(1, 0) == 1) w1c_ovr();
        end

        // Reset mid-frame with rx_valid pending
        w_ctrl(32'h3);
        frame_begin();
        frame_byte(8'h42, "prerst host rx");
        chk_irq("prerst irq");
        spi_byte(8'hF0, 4, mi);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst ena", ena, 0);
        check("rst miso", spi_miso, 0);
        check("rst miso_oe", spi_miso_oe, 0);
        check("rst irq", irq, 0);
        check("rst rdata", mem_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        cs_high();
        rd_st("post-rst status", 0);
        bus_read(A_CTRL, d);
        check("post-rst ctrl", d, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
